// File: rtl/pu_riscv_pmacfg_regs_if.sv
// Request/response bus into the PMA config register file.
// One request per transaction; the slave acks one cycle after accept.
interface pu_riscv_pmacfg_regs_if #(
    parameter int XLEN    = 64,
    parameter int PMA_CNT = 4
);
    localparam int IDX_W = $clog2(PMA_CNT);

    logic             req_i;
    logic             we_i;
    logic             sel_i;
    logic [IDX_W-1:0] idx_i;
    logic [XLEN-1:0]  wdata_i;
    logic [XLEN-1:0]  rdata_o;
    logic             ack_o;
    logic             err_o;

    modport master (
        output req_i, we_i, sel_i, idx_i, wdata_i,
        input  rdata_o, ack_o, err_o
    );

    modport slave (
        input  req_i, we_i, sel_i, idx_i, wdata_i,
        output rdata_o, ack_o, err_o
    );
endinterface

// File: rtl/pu_riscv_pmacfg_regs.sv
// PMA region cfg/address shadow registers, published atomically to the checker on commit.
// Ack one cycle after accept; requests are ignored while busy (RESP), commit is always taken.
module pu_riscv_pmacfg_regs #(
    parameter int              XLEN    = 64,
    parameter int              PMA_CNT = 4,
    parameter logic [13:0]     CFG_RST = 14'h0,
    parameter logic [XLEN-1:0] ADR_RST = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pu_riscv_pmacfg_regs_if.slave         bus,
    input  logic                          commit_i,
    output logic                          busy_o,
    output logic [PMA_CNT-1:0][13:0]      pma_cfg_o,
    output logic [PMA_CNT-1:0][XLEN-1:0]  pma_adr_o
);
    localparam logic [1:0] TOR = 2'b01;

    typedef enum logic {IDLE, RESP} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [PMA_CNT-1:0][13:0]     r_shd_cfg;
    logic [PMA_CNT-1:0][13:0]     r_act_cfg;
    logic [PMA_CNT-1:0][XLEN-1:0] r_shd_adr;
    logic [PMA_CNT-1:0][XLEN-1:0] r_act_adr;
    logic [PMA_CNT-1:0]           r_lock;
    logic [PMA_CNT-1:0]           w_adr_lock;
    logic [XLEN-1:0]              r_rdata;
    logic [XLEN-1:0]              w_rd_cfg;
    logic                         r_err;
    logic                         w_accept;
    logic                         w_idx_ok;

    assign w_accept = (r_state == IDLE) && bus.req_i;
    assign w_idx_ok = 32'(bus.idx_i) < PMA_CNT;

    // A locked TOR region above uses this address as its lower bound.
    for (genvar g = 0; g < PMA_CNT; g++) begin : g_adr_lock
        if (g < PMA_CNT - 1) begin : g_tor
            assign w_adr_lock[g] = r_lock[g] |
                                   (r_lock[g+1] & (r_shd_cfg[g+1][1:0] == TOR));
        end else begin : g_last
            assign w_adr_lock[g] = r_lock[g];
        end
    end

    always_comb begin
        w_rd_cfg        = '0;
        w_rd_cfg[13:0]  = r_shd_cfg[bus.idx_i];
        w_rd_cfg[15]    = r_lock[bus.idx_i];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.req_i) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_lock  <= '0;
            for (int i = 0; i < PMA_CNT; i++) begin
                r_shd_cfg[i] <= CFG_RST;
                r_act_cfg[i] <= CFG_RST;
                r_shd_adr[i] <= ADR_RST;
                r_act_adr[i] <= ADR_RST;
            end
        end else begin
            r_state <= w_state_nxt;
            if (commit_i) begin
                r_act_cfg <= r_shd_cfg;
                r_act_adr <= r_shd_adr;
            end
            if (w_accept) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
                if (!w_idx_ok) begin
                    r_err <= 1'b1;
                end else if (bus.we_i) begin
                    if (!bus.sel_i) begin
                        if (r_lock[bus.idx_i]) begin
                            r_err <= 1'b1;
                        end else begin
                            r_shd_cfg[bus.idx_i] <= bus.wdata_i[13:0];
                            r_lock[bus.idx_i]    <= bus.wdata_i[15];
                        end
                    end else begin
                        if (w_adr_lock[bus.idx_i]) begin
                            r_err <= 1'b1;
                        end else begin
                            r_shd_adr[bus.idx_i] <= bus.wdata_i;
                        end
                    end
                end else begin
                    r_rdata <= bus.sel_i ? r_shd_adr[bus.idx_i] : w_rd_cfg;
                end
            end
        end
    end

    // A reset arriving during RESP drops the transaction without acking it.
    assign bus.ack_o   = (r_state == RESP) && !rst_i;
    assign bus.err_o   = r_err;
    assign bus.rdata_o = r_rdata;
    assign busy_o      = (r_state == RESP);
    assign pma_cfg_o   = r_act_cfg;
    assign pma_adr_o   = r_act_adr;
endmodule
